game_fsm_nxn: RTL and testbench

- Sequential two-player board-game controller for N×N boards, with a full row, column or diagonal required to win.
- Owns both player boards and alternates turns.
- Validates moves, detects win and draw, and enforces an optional per-turn timeout.
- Keeps saturating per-player win scores across games. Feeds board bitmaps and game status to the VGA drawing logic.

---
 rtl/game_fsm_nxn.sv | 210 +++++++++++++++++++++
 tb/tb_game_fsm_nxn.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_nxn.sv
// game_fsm_nxn: two-player N x N board-game controller.
// Owns both player boards, alternates turns, validates moves, detects
// row/column/diagonal wins and draws, enforces an optional per-turn timeout
// and keeps saturating win scores that survive restarts.
module game_fsm_nxn #(
  parameter int N               = 3,
  parameter int IDX_W           = $clog2(N*N+1),
  parameter int TURN_TIMEOUT    = 0,
  parameter int ALTERNATE_START = 1,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               restart,
  input  logic               move_valid,
  input  logic [IDX_W-1:0]   move_idx,
  output logic [N*N-1:0]     board_p1,
  output logic [N*N-1:0]     board_p2,
  output logic [2:0]         state,
  output logic               turn,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic               move_reject,
  output logic               timeout,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
);

  localparam int CELLS   = N*N;
  localparam int LINES   = 2*N + 2;
  localparam int TIMER_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CELLS-1:0] ONE_HOT0 = {{(CELLS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    P1_WAIT   = 3'd1,
    P1_CHECK  = 3'd2,
    P2_WAIT   = 3'd3,
    P2_CHECK  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  // Line k: rows 0..N-1, columns N..2N-1, then main and anti diagonal.
  function automatic logic [CELLS-1:0] line_mask(input int k);
    logic [CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (k < N)           m = m | (ONE_HOT0 << (k*N + i));
      else if (k < 2*N)    m = m | (ONE_HOT0 << (i*N + (k-N)));
      else if (k == 2*N)   m = m | (ONE_HOT0 << (i*N + i));
      else                 m = m | (ONE_HOT0 << (i*N + (N-1-i)));
    end
    return m;
  endfunction

  state_t               state_q, state_d;
  logic [CELLS-1:0]     board_p1_d, board_p2_d;
  logic [1:0]           winner_d;
  logic                 move_reject_d, timeout_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0]   score_p1_d, score_p2_d;
  logic                 start_p2_q, start_p2_d;

  logic [LINES-1:0]     line_p1, line_p2;
  logic                 win_p1, win_p2, board_full;
  logic [CELLS-1:0]     occupied, move_bit;
  logic                 move_legal, timer_expired;

  for (genvar k = 0; k < LINES; k++) begin : g_line
    localparam logic [CELLS-1:0] MASK = line_mask(k);
    assign line_p1[k] = ((board_p1 & MASK) == MASK);
    assign line_p2[k] = ((board_p2 & MASK) == MASK);
  end

  assign win_p1     = |line_p1;
  assign win_p2     = |line_p2;
  assign occupied   = board_p1 | board_p2;
  assign board_full = &occupied;

  // Out-of-range indices shift the single bit off the end, so move_bit is 0.
  assign move_bit   = ONE_HOT0 << move_idx;
  assign move_legal = move_valid && (move_idx < IDX_W'(CELLS)) &&
                      ((occupied & move_bit) == '0);

  assign timer_expired = (TURN_TIMEOUT > 0) &&
                         (timer_q == TIMER_W'(TURN_TIMEOUT - 1));

  // Next-state, board, score and pulse computation; everything holds by default.
  always_comb begin
    state_d       = state_q;
    board_p1_d    = board_p1;
    board_p2_d    = board_p2;
    winner_d      = winner;
    move_reject_d = 1'b0;
    timeout_d     = 1'b0;
    timer_d       = timer_q;
    score_p1_d    = score_p1;
    score_p2_d    = score_p2;
    start_p2_d    = start_p2_q;
    if (restart) begin
      state_d    = IDLE;
      board_p1_d = '0;
      board_p2_d = '0;
      winner_d   = 2'b00;
      timer_d    = '0;
      if (ALTERNATE_START != 0) start_p2_d = ~start_p2_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = start_p2_q ? P2_WAIT : P1_WAIT;
            timer_d = '0;
          end
        end
        P1_WAIT, P2_WAIT: begin
          if (move_legal) begin
            if (state_q == P1_WAIT) begin
              board_p1_d = board_p1 | move_bit;
              state_d    = P1_CHECK;
            end else begin
              board_p2_d = board_p2 | move_bit;
              state_d    = P2_CHECK;
            end
            timer_d = '0;
          end else begin
            move_reject_d = move_valid;
            if (TURN_TIMEOUT > 0) begin
              if (timer_expired) begin
                timeout_d = 1'b1;
                state_d   = (state_q == P1_WAIT) ? P2_WAIT : P1_WAIT;
                timer_d   = '0;
              end else begin
                timer_d = timer_q + TIMER_W'(1);
              end
            end
          end
        end
        P1_CHECK: begin
          if (win_p1) begin
            state_d  = GAME_OVER;
            winner_d = 2'b01;
            if (score_p1 != '1) score_p1_d = score_p1 + SCORE_W'(1);
          end else if (board_full) begin
            state_d  = GAME_OVER;
            winner_d = 2'b11;
          end else begin
            state_d = P2_WAIT;
            timer_d = '0;
          end
        end
        P2_CHECK: begin
          if (win_p2) begin
            state_d  = GAME_OVER;
            winner_d = 2'b10;
            if (score_p2 != '1) score_p2_d = score_p2 + SCORE_W'(1);
          end else if (board_full) begin
            state_d  = GAME_OVER;
            winner_d = 2'b11;
          end else begin
            state_d = P1_WAIT;
            timer_d = '0;
          end
        end
        GAME_OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      board_p1    <= '0;
      board_p2    <= '0;
      winner      <= 2'b00;
      move_reject <= 1'b0;
      timeout     <= 1'b0;
      timer_q     <= '0;
      score_p1    <= '0;
      score_p2    <= '0;
      start_p2_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_p1    <= board_p1_d;
      board_p2    <= board_p2_d;
      winner      <= winner_d;
      move_reject <= move_reject_d;
      timeout     <= timeout_d;
      timer_q     <= timer_d;
      score_p1    <= score_p1_d;
      score_p2    <= score_p2_d;
      start_p2_q  <= start_p2_d;
    end
  end

  // Turn and game_over are decoded straight from the state register.
  always_comb begin
    case (state_q)
      P1_WAIT, P1_CHECK: turn = 1'b0;
      P2_WAIT, P2_CHECK: turn = 1'b1;
      default:           turn = start_p2_q;
    endcase
  end

  assign game_over = (state_q == GAME_OVER);
  assign state     = state_q;

endmodule

// File: tb/tb_game_fsm_nxn.sv
// tb_game_fsm_nxn: table-driven and randomized bench for game_fsm_nxn
// (N=3, 8-cycle turn timeout, alternating start player, 4-bit scores).
module tb_game_fsm_nxn;

  localparam int N     = 3;
  localparam int CELLS = N*N;
  localparam int TT    = 8;
  localparam int SMAX  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, restart = 1'b0, move_valid = 1'b0;
  logic [3:0] move_idx = '0;
  logic [8:0] board_p1, board_p2;
  logic [2:0] state;
  logic       turn, game_over, move_reject, timeout;
  logic [1:0] winner;
  logic [3:0] score_p1, score_p2;

  int n_vectors = 0;
  int n_miscompares = 0;

  game_fsm_nxn #(.N(N), .TURN_TIMEOUT(TT), .ALTERNATE_START(1), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .move_valid(move_valid), .move_idx(move_idx),
    .board_p1(board_p1), .board_p2(board_p2), .state(state), .turn(turn),
    .winner(winner), .game_over(game_over), .move_reject(move_reject),
    .timeout(timeout), .score_p1(score_p1), .score_p2(score_p2)
  );

  always #5 clk = ~clk;

  // Reference model: cells hold 0 (empty), 1 (P1) or 2 (P2).
  int m_cells[CELLS];
  int m_state, m_timer, m_s1, m_s2, m_sp, m_winner;
  int m_rej, m_to;

  function automatic bit m_has_line(int p);
    bit found = 0;
    bit d = 1, a = 1;
    for (int r = 0; r < N; r++) begin
      bit row = 1, col = 1;
      for (int c = 0; c < N; c++) begin
        if (m_cells[r*N+c] != p) row = 0;
        if (m_cells[c*N+r] != p) col = 0;
      end
      if (row || col) found = 1;
      if (m_cells[r*N+r] != p) d = 0;
      if (m_cells[r*N+(N-1-r)] != p) a = 0;
    end
    return found || d || a;
  endfunction

  function automatic bit m_full();
    foreach (m_cells[i]) if (m_cells[i] == 0) return 0;
    return 1;
  endfunction

  function automatic logic [8:0] m_board(int p);
    logic [8:0] b = '0;
    for (int i = 0; i < CELLS; i++) if (m_cells[i] == p) b = b | (9'd1 << i);
    return b;
  endfunction

  task automatic model_step(bit r, bit rs, bit st, bit mv, int idx);
    int p;
    if (r) begin
      foreach (m_cells[i]) m_cells[i] = 0;
      m_state = 0; m_timer = 0; m_s1 = 0; m_s2 = 0; m_sp = 0;
      m_winner = 0; m_rej = 0; m_to = 0;
      return;
    end
    m_rej = 0;
    m_to  = 0;
    if (rs) begin
      foreach (m_cells[i]) m_cells[i] = 0;
      m_winner = 0; m_state = 0; m_timer = 0;
      m_sp = 1 - m_sp;
    end else if (m_state == 0) begin
      if (st) begin
        m_state = (m_sp == 0) ? 1 : 3;
        m_timer = 0;
      end
    end else if (m_state == 1 || m_state == 3) begin
      p = (m_state == 1) ? 1 : 2;
      if (mv && idx < CELLS && m_cells[idx] == 0) begin
        m_cells[idx] = p;
        m_state = m_state + 1;
        m_timer = 0;
      end else begin
        if (mv) m_rej = 1;
        if (m_timer == TT - 1) begin
          m_to = 1;
          m_state = (p == 1) ? 3 : 1;
          m_timer = 0;
        end else begin
          m_timer++;
        end
      end
    end else if (m_state == 2 || m_state == 4) begin
      p = (m_state == 2) ? 1 : 2;
      if (m_has_line(p)) begin
        m_state = 5;
        m_winner = p;
        if (p == 1) m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
        else        m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX;
      end else if (m_full()) begin
        m_state = 5;
        m_winner = 3;
      end else begin
        m_state = (p == 1) ? 3 : 1;
        m_timer = 0;
      end
    end
  endtask

  task automatic check_field(string name, int act, int exp);
    n_vectors++;
    if (act != exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_output();
    int exp_turn;
    exp_turn = (m_state == 1 || m_state == 2) ? 0 :
               (m_state == 3 || m_state == 4) ? 1 : m_sp;
    check_field("state",       int'(state),       m_state);
    check_field("board_p1",    int'(board_p1),    int'(m_board(1)));
    check_field("board_p2",    int'(board_p2),    int'(m_board(2)));
    check_field("turn",        int'(turn),        exp_turn);
    check_field("winner",      int'(winner),      m_winner);
    check_field("game_over",   int'(game_over),   int'(m_state == 5));
    check_field("move_reject", int'(move_reject), m_rej);
    check_field("timeout",     int'(timeout),     m_to);
    check_field("score_p1",    int'(score_p1),    m_s1);
    check_field("score_p2",    int'(score_p2),    m_s2);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check 1ns later.
  task automatic apply_stimulus(bit r, bit rs, bit st, bit mv, int idx);
    rst = r; restart = rs; start = st; move_valid = mv; move_idx = 4'(idx);
    @(posedge clk);
    model_step(r, rs, st, mv, idx);
    #1;
    check_output();
    @(negedge clk);
  endtask

  task automatic play(int idx);
    apply_stimulus(0, 0, 0, 1, idx);
    apply_stimulus(0, 0, 0, 0, 0);
  endtask

  task automatic p1_win_game();
    int p2_first[6] = '{3, 0, 4, 1, 8, 2};
    int p1_first[9] = '{0, 3, 5, 4, 6, 7, 1, 8, 2};
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    if (m_sp == 1) foreach (p2_first[i]) play(p2_first[i]);
    else           foreach (p1_first[i]) play(p1_first[i]);
    check_field("p1_win_winner", int'(winner), 1);
    check_field("p1_win_over",   int'(game_over), 1);
  endtask

  typedef struct {
    bit rs, st, mv;
    int idx;
    int e_state, e_b1, e_b2, e_w, e_rej, e_s1;
  } vec_t;

  function automatic vec_t mk(bit rs, bit st, bit mv, int idx, int es,
                              int eb1, int eb2, int ew, int erej, int es1);
    vec_t v;
    v.rs = rs; v.st = st; v.mv = mv; v.idx = idx;
    v.e_state = es; v.e_b1 = eb1; v.e_b2 = eb2; v.e_w = ew;
    v.e_rej = erej; v.e_s1 = es1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Row-0 win for P1, hold in GAME_OVER, restarts, rejects and out-of-range.
    tbl.push_back(mk(0,1,0,0,  1, 'h000,'h000,0,0,0));
    tbl.push_back(mk(0,0,1,0,  2, 'h001,'h000,0,0,0));
    tbl.push_back(mk(0,0,0,0,  3, 'h001,'h000,0,0,0));
    tbl.push_back(mk(0,0,1,3,  4, 'h001,'h008,0,0,0));
    tbl.push_back(mk(0,0,0,0,  1, 'h001,'h008,0,0,0));
    tbl.push_back(mk(0,0,1,1,  2, 'h003,'h008,0,0,0));
    tbl.push_back(mk(0,0,0,0,  3, 'h003,'h008,0,0,0));
    tbl.push_back(mk(0,0,1,4,  4, 'h003,'h018,0,0,0));
    tbl.push_back(mk(0,0,0,0,  1, 'h003,'h018,0,0,0));
    tbl.push_back(mk(0,0,1,2,  2, 'h007,'h018,0,0,0));
    tbl.push_back(mk(0,0,0,0,  5, 'h007,'h018,1,0,1));
    tbl.push_back(mk(0,0,1,5,  5, 'h007,'h018,1,0,1));
    tbl.push_back(mk(1,0,0,0,  0, 'h000,'h000,0,0,1));
    tbl.push_back(mk(0,1,0,0,  3, 'h000,'h000,0,0,1));
    tbl.push_back(mk(1,0,0,0,  0, 'h000,'h000,0,0,1));
    tbl.push_back(mk(0,1,0,0,  1, 'h000,'h000,0,0,1));
    tbl.push_back(mk(0,0,1,4,  2, 'h010,'h000,0,0,1));
    tbl.push_back(mk(0,0,0,0,  3, 'h010,'h000,0,0,1));
    tbl.push_back(mk(0,0,1,4,  3, 'h010,'h000,0,1,1));
    tbl.push_back(mk(0,0,0,0,  3, 'h010,'h000,0,0,1));
    tbl.push_back(mk(0,0,1,8,  4, 'h010,'h100,0,0,1));
    tbl.push_back(mk(0,0,0,0,  1, 'h010,'h100,0,0,1));
    tbl.push_back(mk(0,0,1,9,  1, 'h010,'h100,0,1,1));
    tbl.push_back(mk(0,0,0,0,  1, 'h010,'h100,0,0,1));
    tbl.push_back(mk(0,0,1,15, 1, 'h010,'h100,0,1,1));
    tbl.push_back(mk(0,0,0,0,  1, 'h010,'h100,0,0,1));

    @(negedge clk);
    apply_stimulus(1, 0, 0, 0, 0);
    check_field("reset_state", int'(state), 0);
    check_field("reset_score", int'(score_p1), 0);
    apply_stimulus(0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply_stimulus(0, tbl[i].rs, tbl[i].st, tbl[i].mv, tbl[i].idx);
      check_field($sformatf("tbl%0d_state", i),    int'(state),       tbl[i].e_state);
      check_field($sformatf("tbl%0d_board_p1", i), int'(board_p1),    tbl[i].e_b1);
      check_field($sformatf("tbl%0d_board_p2", i), int'(board_p2),    tbl[i].e_b2);
      check_field($sformatf("tbl%0d_winner", i),   int'(winner),      tbl[i].e_w);
      check_field($sformatf("tbl%0d_reject", i),   int'(move_reject), tbl[i].e_rej);
      check_field($sformatf("tbl%0d_score_p1", i), int'(score_p1),    tbl[i].e_s1);
    end

    // Draw game: full board with no line for either player.
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    begin
      int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      foreach (draw_seq[i]) play(draw_seq[i]);
    end
    check_field("draw_winner",   int'(winner),   3);
    check_field("draw_board_p1", int'(board_p1), 'h18D);
    check_field("draw_board_p2", int'(board_p2), 'h072);
    check_field("draw_score_p1", int'(score_p1), 1);
    check_field("draw_score_p2", int'(score_p2), 0);

    // Turn timeout, then a legal move on the expiring cycle.
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < TT - 1; i++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_field("to_wait_state", int'(state), 1);
      check_field("to_wait_pulse", int'(timeout), 0);
    end
    apply_stimulus(0, 0, 0, 0, 0);
    check_field("to_fire_state", int'(state), 3);
    check_field("to_fire_pulse", int'(timeout), 1);
    for (int i = 0; i < TT - 1; i++) apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_field("to_move_state", int'(state), 4);
    check_field("to_move_pulse", int'(timeout), 0);
    check_field("to_move_board", int'(board_p2), 'h001);
    apply_stimulus(0, 0, 0, 0, 0);

    // Score saturation over many P1 wins, then reset clears everything.
    for (int g = 0; g < 16; g++) p1_win_game();
    check_field("sat_score_p1", int'(score_p1), 15);
    check_field("sat_score_p2", int'(score_p2), 0);
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_field("rst_score_p1", int'(score_p1), 0);
    check_field("rst_turn",     int'(turn),     0);
    check_field("rst_board",    int'(board_p1), 0);

    // Randomized play against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit r, rs, st, mv;
      int idx;
      r   = ($urandom_range(0, 299) == 0);
      rs  = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      mv  = ($urandom_range(0, 3) == 0);
      idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15))
                                        : int'($urandom_range(0, 8));
      apply_stimulus(r, rs, st, mv, idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
